// File: rtl/seq_det_pkg.sv
// Shared types, constants and helpers for the multi-channel 01[0*]1 detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no useful prefix
        S0   = 2'd1,   // last bit 0, no pending 01
        S01  = 2'd2,   // 01 just seen
        S010 = 2'd3    // 01 followed by one or more 0s
    } state_t;

    // Active-low 7-segment patterns, bit 0 = segment a, indexed by BCD digit.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Segment pattern for one BCD digit; non-BCD codes show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        if (d > 4'd9) return SEG_BLANK;
        return SEG_TABLE[d];
    endfunction

    // One BCD digit plus carry-in; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_incr(input logic [3:0] d, input logic cin);
        if (!cin)      return {1'b0, d};
        if (d == 4'd9) return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

endpackage

// File: rtl/seq_det_channel.sv
// One channel: Mealy 01[0*]1 detector, BCD occurrence counter, sticky overflow.
module seq_det_channel
    import seq_det_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  sig,
    input  logic                  overlap,
    input  logic                  sat_mode,
    output logic                  z,
    output logic [4*DIGITS-1:0]   count,
    output logic                  ovf
);

    state_t                state, state_nxt;
    logic [4*DIGITS-1:0]   count_inc;
    logic [DIGITS:0]       carry;

    // Next state and Mealy match; ena low holds state and suppresses z.
    always_comb begin
        state_nxt = state;
        z         = 1'b0;
        if (ena) begin
            case (state)
                IDLE: state_nxt = sig ? IDLE : S0;
                S0:   state_nxt = sig ? S01  : S0;
                S01: begin
                    if (sig) begin
                        z         = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = S010;
                    end
                end
                S010: begin
                    if (sig) begin
                        z         = 1'b1;
                        // the final 1 can double as the 1 of a new 01
                        state_nxt = overlap ? S01 : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ripple BCD increment; carry out of the top digit means count was at max.
    always_comb begin
        carry[0]  = 1'b1;
        count_inc = '0;
        for (int k = 0; k < DIGITS; k++) begin
            {carry[k+1], count_inc[4*k +: 4]} = bcd_incr(count[4*k +: 4], carry[k]);
        end
    end

    // State, counter and overflow registers; a wrapped increment is already 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (z) begin
                if (carry[DIGITS]) begin
                    ovf <= 1'b1;
                    if (!sat_mode) count <= count_inc;
                end else begin
                    count <= count_inc;
                end
            end
        end
    end

endmodule

// File: rtl/multi_sequence_detector.sv
// CHANNELS independent 01[0*]1 detectors with BCD counters; one count is
// selected at run time and shown on registered active-low 7-segment digits.
module multi_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIGITS   = 2,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [CHANNELS-1:0]   sig_to_test,
    input  logic                  overlap,
    input  logic                  sat_mode,
    input  logic [SEL_W-1:0]      disp_sel,
    output logic [7*DIGITS-1:0]   disp,
    output logic [CHANNELS-1:0]   z,
    output logic [CHANNELS-1:0]   ovf
);

    logic [CHANNELS-1:0][4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0]               sel_count;
    logic                              sel_hit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        seq_det_channel #(.DIGITS(DIGITS)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .sig      (sig_to_test[i]),
            .overlap  (overlap),
            .sat_mode (sat_mode),
            .z        (z[i]),
            .count    (count[i]),
            .ovf      (ovf[i])
        );
    end

    // Display channel select; a code past the last channel finds no hit.
    always_comb begin
        sel_count = '0;
        sel_hit   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (disp_sel == SEL_W'(i)) begin
                sel_count = count[i];
                sel_hit   = 1'b1;
            end
        end
    end

    // Registered segment decode of the selected count.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= {DIGITS{SEG_ZERO}};
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                disp[7*k +: 7] <= sel_hit ? seg7(sel_count[4*k +: 4]) : SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_multi_sequence_detector.sv
// Randomized and directed check of multi_sequence_detector against a
// history-based reference model. Two instances share stimulus: A (4 ch,
// 2 digits) and B (3 ch, 1 digit, so disp_sel=3 is out of range).
module tb_multi_sequence_detector;

    logic        clk = 1'b0;
    logic        rst, ena, overlap, sat_mode;
    logic [3:0]  sig;
    logic [1:0]  sel;
    logic [13:0] disp_a;
    logic [3:0]  z_a, ovf_a;
    logic [6:0]  disp_b;
    logic [2:0]  z_b, ovf_b;

    always #5 clk = ~clk;

    multi_sequence_detector #(.CHANNELS(4), .DIGITS(2)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig), .overlap(overlap),
        .sat_mode(sat_mode), .disp_sel(sel), .disp(disp_a), .z(z_a), .ovf(ovf_a));

    multi_sequence_detector #(.CHANNELS(3), .DIGITS(1)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig[2:0]), .overlap(overlap),
        .sat_mode(sat_mode), .disp_sel(sel), .disp(disp_b), .z(z_b), .ovf(ovf_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    bit          hist [4][$];      // bits seen since the last restart point
    int          cnt_a [4];
    int          cnt_b [3];
    logic [3:0]  ovf_a_m;
    logic [2:0]  ovf_b_m;
    logic [13:0] disp_a_m;
    logic [6:0]  disp_b_m;
    int          zcnt0;
    logic [3:0]  last_z;

    // Match when history plus b ends in 0 1 0* 1.
    function automatic bit would_match(int ch, bit b);
        int j;
        if (!b) return 1'b0;
        j = hist[ch].size() - 1;
        while (j >= 0 && hist[ch][j] == 1'b0) j--;
        return (j >= 1) && (hist[ch][j-1] == 1'b0);
    endfunction

    function automatic logic [13:0] enc_a(int c);
        return {seg_tab[(c / 10) % 10], seg_tab[c % 10]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            hist[c].delete();
            cnt_a[c] = 0;
        end
        for (int c = 0; c < 3; c++) cnt_b[c] = 0;
        ovf_a_m  = '0;
        ovf_b_m  = '0;
        disp_a_m = 14'h2040;
        disp_b_m = 7'h40;
    endtask

    task automatic model_edge(input logic [3:0] zexp);
        if (rst) begin
            model_reset();
            return;
        end
        disp_a_m = enc_a(cnt_a[sel]);
        if (sel < 2'd3) disp_b_m = seg_tab[cnt_b[sel]];
        else            disp_b_m = 7'h7f;
        if (!ena) return;
        for (int c = 0; c < 4; c++) begin
            if (zexp[c] && !overlap) hist[c].delete();
            else                     hist[c].push_back(sig[c]);
            if (zexp[c]) begin
                if (cnt_a[c] == 99) begin
                    ovf_a_m[c] = 1'b1;
                    if (!sat_mode) cnt_a[c] = 0;
                end else cnt_a[c]++;
                if (c < 3) begin
                    if (cnt_b[c] == 9) begin
                        ovf_b_m[c] = 1'b1;
                        if (!sat_mode) cnt_b[c] = 0;
                    end else cnt_b[c]++;
                end
            end
        end
    endtask

    // One clock: compare at the falling edge, advance model at the rising edge.
    task automatic cyc();
        logic [3:0] zexp;
        @(negedge clk);
        for (int c = 0; c < 4; c++) zexp[c] = ena && would_match(c, sig[c]);
        check("z_a",    32'(z_a),    32'(zexp));
        check("z_b",    32'(z_b),    32'(zexp[2:0]));
        check("disp_a", 32'(disp_a), 32'(disp_a_m));
        check("disp_b", 32'(disp_b), 32'(disp_b_m));
        check("ovf_a",  32'(ovf_a),  32'(ovf_a_m));
        check("ovf_b",  32'(ovf_b),  32'(ovf_b_m));
        zcnt0 += int'(z_a[0]);
        last_z = z_a;
        @(posedge clk);
        model_edge(zexp);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig = '0;
        cyc();
        rst = 1'b0;
    endtask

    logic [23:0] stream;

    initial begin
        stream   = 24'b000100110001011101010011;
        rst      = 1'b1;
        ena      = 1'b1;
        overlap  = 1'b1;
        sat_mode = 1'b1;
        sig      = '0;
        sel      = '0;
        zcnt0    = 0;
        last_z   = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();   // reset values checked inside cyc

        // Overlapping count on channel 0
        zcnt0 = 0;
        for (int i = 1; i <= 24; i++) begin
            sig = {3'b000, stream[24-i]};
            cyc();
        end
        sig = '0;
        cyc();
        check("ovl_zcount", 32'(zcnt0), 32'd7);
        check("ovl_disp",   32'(disp_a), 32'({7'h40, 7'h78}));

        // Non-overlapping count
        overlap = 1'b0;
        do_reset();
        zcnt0 = 0;
        for (int i = 1; i <= 24; i++) begin
            sig = {3'b000, stream[24-i]};
            cyc();
        end
        sig = '0;
        cyc();
        check("novl_zcount", 32'(zcnt0), 32'd4);
        check("novl_disp",   32'(disp_a), 32'({7'h40, 7'h19}));

        // Parallel channels: ch1 stream, ch2 one-bit delayed copy
        overlap = 1'b1;
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            sig = '0;
            if (i <= 24) sig[1] = stream[24-i];
            if (i >= 2)  sig[2] = stream[25-i];
            cyc();
        end
        sig = '0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cyc();
            check("par_disp_a", 32'(disp_a), (s == 1 || s == 2) ? 32'h2078 : 32'h2040);
            check("par_disp_b", 32'(disp_b), (s == 3) ? 32'h7f : ((s == 0) ? 32'h40 : 32'h78));
        end

        // Saturate then wrap, "011" x12 on all channels
        for (int m = 0; m < 2; m++) begin
            sat_mode = (m == 0);
            sel      = 2'd0;
            do_reset();
            for (int r = 0; r < 12; r++) begin
                sig = 4'h0; cyc();
                sig = 4'hf; cyc();
                sig = 4'hf; cyc();
            end
            sig = '0;
            cyc();
            check("sat_disp_b", 32'(disp_b), (m == 0) ? 32'h10 : 32'h24);
            check("sat_ovf_b",  32'(ovf_b),  32'h7);
            check("sat_disp_a", 32'(disp_a), 32'({7'h79, 7'h24}));
        end

        // Enable drop inside "0100", resume with "1"
        sig = 4'h0; cyc();
        sig = 4'h1; cyc();
        sig = 4'h0; cyc();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sig = 4'($urandom_range(0, 15));
            cyc();
            check("ena_z_low", 32'(last_z), 32'h0);
        end
        ena = 1'b1;
        sig = 4'h0; cyc();
        sig = 4'h1; cyc();
        check("ena_resume_z", 32'(last_z[0]), 32'h1);

        // Reset after "01" discards the prefix and the counts
        sig = 4'h0; cyc();
        sig = 4'h1; cyc();
        rst = 1'b1; sig = 4'h0; cyc();
        rst = 1'b0;
        sig = 4'h1; cyc();
        check("rst_no_match", 32'(last_z), 32'h0);
        check("rst_disp_a",   32'(disp_a), 32'h2040);
        check("rst_disp_b",   32'(disp_b), 32'h40);
        check("rst_ovf",      32'({ovf_a, ovf_b}), 32'h0);

        // Random traffic: modes, enable, selector and occasional reset;
        // second half has no reset so the 2-digit counters can overflow.
        for (int n = 0; n < 4000; n++) begin
            sig = 4'($urandom_range(0, 15));
            ena = ($urandom_range(0, 9) != 0);
            rst = (n < 2000) && ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) overlap  = ~overlap;
            if ($urandom_range(0, 29) == 0) sat_mode = ~sat_mode;
            if ($urandom_range(0, 7) == 0)  sel      = 2'($urandom_range(0, 3));
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
